// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// default measurement constants used as parameter defaults by the top.
package clk_period_meter_pkg;

   // Measurement FSM: ARM waits for a reference rising edge, RUN counts.
   typedef enum logic {
      ST_ARM = 1'b0,
      ST_RUN = 1'b1
   } state_t;

   // Defaults sized for monitoring a divide-by-3 clock.
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_EXP_MIN     = 3;
   localparam int DEF_EXP_MAX     = 3;
   localparam int DEF_TIMEOUT     = 1024;
   localparam int DEF_ERR_W       = 8;

endpackage : clk_period_meter_pkg

// File: rtl/clk_period_meter_sync_edge_det.sv
// Front end of the period meter: brings the asynchronous monitored clock
// into the clk_in domain through a synchronizer chain, then delays it one
// more cycle so a rising edge can be detected as s & ~s_d.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic sig_in,
   output logic s,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              s_d;

   // Synchronizer chain followed by the edge-detect delay flop.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each stage samples the previous
         // stage's old value; blocking here would collapse the chain.
         sync_q <= {sync_q[STAGES-2:0], sig_in};
         s_d    <= sync_q[STAGES-1];
      end
   end

   assign s    = sync_q[STAGES-1];
   assign rise = s & ~s_d;

endmodule : sync_edge_det

// File: rtl/clk_period_meter.sv
// On-chip period checker for a slow (divided) clock sampled as data in the
// clk_in domain. Measures rise-to-rise period and high time in clk_in
// cycles, flags out-of-range periods with a saturating error counter, and
// raises a sticky timeout when the monitored clock stops toggling.
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int EXP_MIN     = DEF_EXP_MIN,
   parameter int EXP_MAX     = DEF_EXP_MAX,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int ERR_W       = DEF_ERR_W
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             clr,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             in_range,
   output logic [ERR_W-1:0] err_cnt,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] hcnt_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic             cnt_ok;
   logic             s;
   logic             rise;

   sync_edge_det #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .s      (s),
      .rise   (rise)
   );

   // Saturating increments and the range test on the running period count.
   always_comb begin
      // NOTE: defaults first so every path assigns every variable and no
      // latch is inferred.
      cnt_nxt  = cnt;
      hcnt_nxt = hcnt;
      err_nxt  = err_cnt;
      cnt_ok   = (cnt >= EXP_MIN_C) && (cnt <= EXP_MAX_C);
      if (cnt != CNT_MAX) begin
         cnt_nxt = cnt + CNT_ONE;
      end
      if (s && (hcnt != CNT_MAX)) begin
         hcnt_nxt = hcnt + CNT_ONE;
      end
      if (!cnt_ok && (err_cnt != ERR_MAX)) begin
         err_nxt = err_cnt + ERR_ONE;
      end
   end

   // Measurement FSM with counters and registered outputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_ARM;
         cnt        <= '0;
         hcnt       <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         in_range   <= 1'b0;
         err_cnt    <= '0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (clr) begin
            // Clear beats a coincident rise: re-arm without measuring.
            state   <= ST_ARM;
            err_cnt <= '0;
            timeout <= 1'b0;
         end else begin
            case (state)
               ST_ARM: begin
                  // The first rise only sets the reference point.
                  if (rise) begin
                     cnt   <= CNT_ONE;
                     hcnt  <= CNT_ONE;
                     state <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (rise) begin
                     period     <= cnt;
                     high_time  <= hcnt;
                     meas_valid <= 1'b1;
                     in_range   <= cnt_ok;
                     err_cnt    <= err_nxt;
                     timeout    <= 1'b0;
                     cnt        <= CNT_ONE;
                     hcnt       <= CNT_ONE;
                  end else if (cnt == TIMEOUT_C) begin
                     // Stalled clock: keep the last period/high_time visible.
                     timeout  <= 1'b1;
                     in_range <= 1'b0;
                     state    <= ST_ARM;
                  end else begin
                     cnt  <= cnt_nxt;
                     hcnt <= hcnt_nxt;
                  end
               end
               default: state <= ST_ARM;
            endcase
         end
      end
   end

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter. A reference model works on the
// driven bit stream (delayed by the synchronizer depth), pushes expected
// measurements into a scoreboard queue at each modelled rise, and pops them
// when the DUT pulses meas_valid. A second instance with ERR_W=2 shares the
// stimulus to exercise error-counter saturation.
module tb_clk_period_meter;
   import clk_period_meter_pkg::*;

   localparam int SYNC    = 2;
   localparam int CNT_W   = 16;
   localparam int ERR_W   = 8;
   localparam int ERR_W2  = 2;
   localparam int EXP_MIN = 3;
   localparam int EXP_MAX = 3;
   localparam int TIMEOUT = 1024;
   localparam int ERR_SAT  = (1 << ERR_W) - 1;
   localparam int ERR_SAT2 = (1 << ERR_W2) - 1;

   logic              clk_in = 1'b0;
   logic              rst_n  = 1'b1;
   logic              sig_in = 1'b0;
   logic              clr    = 1'b0;
   logic [CNT_W-1:0]  period, high_time;
   logic              meas_valid, in_range, timeout;
   logic [ERR_W-1:0]  err_cnt;
   logic [CNT_W-1:0]  period2, high_time2;
   logic              meas_valid2, in_range2, timeout2;
   logic [ERR_W2-1:0] err_cnt2;

   clk_period_meter #(
      .SYNC_STAGES (SYNC), .CNT_W (CNT_W), .EXP_MIN (EXP_MIN),
      .EXP_MAX (EXP_MAX), .TIMEOUT (TIMEOUT), .ERR_W (ERR_W)
   ) dut (
      .clk_in (clk_in), .rst_n (rst_n), .sig_in (sig_in), .clr (clr),
      .period (period), .high_time (high_time), .meas_valid (meas_valid),
      .in_range (in_range), .err_cnt (err_cnt), .timeout (timeout)
   );

   clk_period_meter #(
      .SYNC_STAGES (SYNC), .CNT_W (CNT_W), .EXP_MIN (EXP_MIN),
      .EXP_MAX (EXP_MAX), .TIMEOUT (TIMEOUT), .ERR_W (ERR_W2)
   ) dut_e2 (
      .clk_in (clk_in), .rst_n (rst_n), .sig_in (sig_in), .clr (clr),
      .period (period2), .high_time (high_time2), .meas_valid (meas_valid2),
      .in_range (in_range2), .err_cnt (err_cnt2), .timeout (timeout2)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int per;
      int hi;
      bit ir;
   } meas_t;

   meas_t sb[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit dl[SYNC];
   bit d_prev;
   bit running;
   int t;
   int last_rise;
   int hi;
   int err_m;
   int err2_m;
   bit to_m;
   bit mv_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < SYNC; i++) dl[i] = 1'b0;
      d_prev  = 1'b0;
      running = 1'b0;
      err_m   = 0;
      err2_m  = 0;
      to_m    = 1'b0;
      mv_m    = 1'b0;
      sb.delete();
   endtask

   // Advance the model by one clk_in cycle with driven bit b and clear c.
   task automatic model_update(input bit b, input bit c);
      bit    d, rise_m;
      meas_t m;
      d = dl[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0]  = b;
      rise_m = d & ~d_prev;
      d_prev = d;
      t++;
      mv_m = 1'b0;
      if (c) begin
         running = 1'b0;
         err_m   = 0;
         err2_m  = 0;
         to_m    = 1'b0;
      end else if (!running) begin
         if (rise_m) begin
            running   = 1'b1;
            last_rise = t;
            hi        = 1;
         end
      end else if (rise_m) begin
         m.per = t - last_rise;
         m.hi  = hi;
         m.ir  = (m.per >= EXP_MIN) && (m.per <= EXP_MAX);
         sb.push_back(m);
         if (!m.ir) begin
            if (err_m < ERR_SAT) err_m++;
            if (err2_m < ERR_SAT2) err2_m++;
         end
         to_m      = 1'b0;
         mv_m      = 1'b1;
         last_rise = t;
         hi        = 1;
      end else if (t - last_rise == TIMEOUT) begin
         running = 1'b0;
         to_m    = 1'b1;
      end else begin
         hi += int'(d);
      end
   endtask

   task automatic check_outputs();
      meas_t m;
      check("meas_valid", meas_valid, mv_m);
      if (meas_valid === 1'b1) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            m = sb.pop_front();
            check("period", period, m.per);
            check("high_time", high_time, m.hi);
            check("in_range", in_range, m.ir);
         end
      end
      check("err_cnt", err_cnt, err_m);
      check("timeout", timeout, to_m);
      check("err_cnt_w2", err_cnt2, err2_m);
   endtask

   task automatic step(input bit b, input bit c);
      @(posedge clk_in);
      #1;
      check_outputs();
      sig_in = b;
      clr    = c;
      model_update(b, c);
   endtask

   task automatic periods(input int h, input int l, input int n);
      repeat (n) begin
         repeat (h) step(1'b1, 1'b0);
         repeat (l) step(1'b0, 1'b0);
      end
   endtask

   task automatic hold(input bit b, input int n);
      repeat (n) step(b, 1'b0);
   endtask

   // Assert reset away from the clock edge, check outputs clear at once.
   task automatic apply_reset();
      @(posedge clk_in);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_period", period, 0);
      check("rst_high_time", high_time, 0);
      check("rst_meas_valid", meas_valid, 0);
      check("rst_in_range", in_range, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_timeout", timeout, 0);
      check("rst_err_cnt_w2", err_cnt2, 0);
      model_clear();
      repeat (3) @(posedge clk_in);
      #1;
      rst_n = 1'b1;
      model_update(sig_in, 1'b0);
   endtask

   initial begin
      t = 0;
      model_clear();
      apply_reset();
      hold(1'b0, 4);

      // 3-cycle clock, high 2 / low 1: in range.
      periods(2, 1, 11);
      // div_3 style clock, high 1 / low 2: in range.
      periods(1, 2, 8);
      // Period 4: out of range, err_cnt counts; the ERR_W=2 copy sticks at 3.
      periods(2, 2, 6);
      // Stall low: timeout exactly TIMEOUT cycles after the last rise.
      hold(1'b0, 1100);
      // Restart: first rise arms, second measures and drops timeout.
      periods(2, 1, 4);

      // Clear coincident with a rise: no measurement, err_cnt zeroed.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      periods(2, 1, 4);

      // Reset in the middle of a high phase, then resume.
      step(1'b1, 1'b0);
      apply_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      periods(2, 1, 4);

      // Flat high ends in timeout as well.
      hold(1'b1, TIMEOUT + 8);
      hold(1'b0, 6);

      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_clk_period_meter
